// File: rtl/ssd_driver_if.sv
// ============================================================================
// Module      : ssd_driver_if
// Description : Value/display bundle between the datapath and ssd_driver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ssd_driver_if;
    logic [12:0] num;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic [15:0] bcd_out;
    logic        busy;

    modport master (
        output num,
        input  anode,
        input  seg,
        input  bcd_out,
        input  busy
    );

    modport slave (
        input  num,
        output anode,
        output seg,
        output bcd_out,
        output busy
    );
endinterface

`default_nettype wire

// File: rtl/ssd_driver.sv
// ============================================================================
// Module      : ssd_driver
// Description : Sequential double-dabble binary-to-BCD converter driving a
//               4-digit multiplexed common-anode seven-segment display.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ssd_driver #(
    parameter int REFRESH_BITS = 17,
    parameter bit BLANK_LZ     = 1'b1
) (
    input  wire logic    clk,
    input  wire logic    Reset,
    ssd_driver_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [REFRESH_BITS-1:0] c_ref_one = {{(REFRESH_BITS-1){1'b0}}, 1'b1};

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_load;
    logic                    w_shift;
    logic                    w_commit;

    logic [28:0]             r_shift;
    logic [28:0]             w_adj;
    logic [12:0]             r_last;
    logic [3:0]              r_iter;
    logic [15:0]             r_bcd;
    logic                    r_busy;

    logic [REFRESH_BITS-1:0] r_refresh;
    logic [1:0]              w_digit;
    logic [3:0]              w_idx;
    logic [3:0]              w_nib;
    logic                    w_blank;
    logic [3:0]              r_anode;
    logic [6:0]              r_seg;

    function automatic logic [6:0] f_decode(input logic [3:0] n);
        case (n)
            4'd0:    f_decode = 7'b1000000;
            4'd1:    f_decode = 7'b1111001;
            4'd2:    f_decode = 7'b0100100;
            4'd3:    f_decode = 7'b0110000;
            4'd4:    f_decode = 7'b0011001;
            4'd5:    f_decode = 7'b0010010;
            4'd6:    f_decode = 7'b0000010;
            4'd7:    f_decode = 7'b1111000;
            4'd8:    f_decode = 7'b0000000;
            4'd9:    f_decode = 7'b0010000;
            default: f_decode = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!Reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.num != r_last) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_CONV;
                end
            end
            S_CONV: begin
                w_shift = 1'b1;
                if (r_iter == 4'd12) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_commit    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // BCD nibbles live in r_shift[28:13]; binary input in r_shift[12:0].
    always_comb begin
        w_adj = r_shift;
        for (int i = 0; i < 4; i++) begin
            if (r_shift[13+4*i +: 4] >= 4'd5)
                w_adj[13+4*i +: 4] = r_shift[13+4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            r_shift <= '0;
            r_last  <= '0;
            r_iter  <= '0;
            r_bcd   <= '0;
            r_busy  <= 1'b0;
        end else begin
            if (w_load) begin
                r_shift <= {16'd0, bus.num};
                r_last  <= bus.num;
                r_iter  <= '0;
                r_busy  <= 1'b1;
            end
            if (w_shift) begin
                r_shift <= {w_adj[27:0], 1'b0};
                r_iter  <= r_iter + 4'd1;
            end
            if (w_commit) begin
                r_bcd  <= r_shift[28:13];
                r_busy <= 1'b0;
            end
        end
    end

    assign w_digit = r_refresh[REFRESH_BITS-1 -: 2];
    assign w_idx   = {w_digit, 2'b00};
    assign w_nib   = r_bcd[w_idx +: 4];
    // A digit is a leading zero when it and every higher nibble are zero.
    assign w_blank = BLANK_LZ && (w_digit != 2'd0) && ((r_bcd >> w_idx) == 16'd0);

    always_ff @(posedge clk) begin
        if (!Reset) begin
            r_refresh <= '0;
            r_anode   <= 4'b1111;
            r_seg     <= 7'b1111111;
        end else begin
            r_refresh <= r_refresh + c_ref_one;
            r_anode   <= ~(4'b0001 << w_digit);
            r_seg     <= w_blank ? 7'b1111111 : f_decode(w_nib);
        end
    end

    assign bus.anode   = r_anode;
    assign bus.seg     = r_seg;
    assign bus.bcd_out = r_bcd;
    assign bus.busy    = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_ssd_driver.sv
// Bench for ssd_driver: decimal-arithmetic reference model compared every
// cycle, plus directed scenarios with literal expectations.
`default_nettype none

module tb_ssd_driver;
    localparam int RB = 4;

    logic clk = 1'b0;
    logic Reset;
    ssd_driver_if bus ();

    ssd_driver #(.REFRESH_BITS(RB), .BLANK_LZ(1'b1)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int pow10(input int d);
        int p = 1;
        for (int k = 0; k < d; k++) p = p * 10;
        return p;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    int         m_val, m_last, m_cap, m_timer, m_ref, m_d;
    logic       m_busy;
    logic [3:0] m_anode;
    logic [6:0] m_seg;
    bit         m_valid = 0;

    always @(posedge clk) begin
        if (!Reset) begin
            m_val = 0; m_last = 0; m_cap = 0; m_timer = 0; m_ref = 0;
            m_busy = 1'b0; m_anode = 4'hF; m_seg = 7'h7F;
        end else begin
            m_d     = (m_ref >> (RB - 2)) & 3;
            m_anode = ~(4'b0001 << m_d);
            if (m_d > 0 && m_val < pow10(m_d)) m_seg = 7'h7F;
            else                               m_seg = seg_of((m_val / pow10(m_d)) % 10);
            m_ref = (m_ref + 1) % (1 << RB);
            if (m_timer == 0) begin
                if (int'(bus.num) != m_last) begin
                    m_cap = int'(bus.num); m_last = m_cap; m_timer = 14; m_busy = 1'b1;
                end
            end else begin
                m_timer--;
                if (m_timer == 0) begin
                    m_val = m_cap; m_busy = 1'b0;
                end
            end
        end
        m_valid = 1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_anode", bus.anode,   m_anode);
            chk("model_seg",   bus.seg,     m_seg);
            chk("model_bcd",   bus.bcd_out, to_bcd(m_val));
            chk("model_busy",  bus.busy,    m_busy);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_bcd(input logic [15:0] v, input string name);
        int n = 0;
        @(negedge clk);
        while (bus.bcd_out !== v && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(name, bus.bcd_out, v);
    endtask

    task automatic wait_digit(input int d, input logic [6:0] exp, input string name);
        int n = 0;
        logic [3:0] want;
        want = ~(4'b0001 << d);
        @(negedge clk);
        while (bus.anode !== want && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_anode"}, bus.anode, want);
        chk(name, bus.seg, exp);
    endtask

    logic [3:0] prev;

    initial begin
        Reset   = 1'b0;
        bus.num = 13'd0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_anode", bus.anode,   4'hF);
        chk("rst_seg",   bus.seg,     7'h7F);
        chk("rst_busy",  bus.busy,    1'b0);
        chk("rst_bcd",   bus.bcd_out, 16'h0);
        Reset = 1'b1;
        @(negedge clk);
        chk("rel_anode", bus.anode, 4'b1110);
        chk("rel_seg",   bus.seg,   7'b1000000);

        // 1234: exact latency
        bus.num = 13'd1234;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            chk("busy_1234", bus.busy, 1'b1);
            chk("bcd_hold",  bus.bcd_out, 16'h0);
        end
        @(negedge clk);
        chk("bcd_1234",  bus.bcd_out, 16'h1234);
        chk("idle_1234", bus.busy, 1'b0);
        wait_digit(0, 7'b0011001, "d0_1234");
        wait_digit(1, 7'b0110000, "d1_1234");
        wait_digit(2, 7'b0100100, "d2_1234");
        wait_digit(3, 7'b1111001, "d3_1234");

        // max value, then zero with blanking
        bus.num = 13'd8191;
        wait_bcd(16'h8191, "bcd_8191");
        wait_digit(1, 7'b0010000, "d1_8191");
        wait_digit(3, 7'b0000000, "d3_8191");
        bus.num = 13'd0;
        wait_bcd(16'h0000, "bcd_0");
        wait_digit(0, 7'b1000000, "d0_zero");
        wait_digit(1, 7'h7F, "d1_blank");
        wait_digit(2, 7'h7F, "d2_blank");
        wait_digit(3, 7'h7F, "d3_blank");

        // change during conversion: old value commits first
        bus.num = 13'd7;
        repeat (5) @(negedge clk);
        bus.num = 13'd905;
        wait_bcd(16'h0007, "bcd_7_first");
        wait_bcd(16'h0905, "bcd_905");
        wait_digit(1, 7'b1000000, "d1_905");
        wait_digit(2, 7'b0010000, "d2_905");
        wait_digit(3, 7'h7F, "d3_905");

        // reset during conversion
        bus.num = 13'd4321;
        repeat (6) @(negedge clk);
        Reset = 1'b0;
        @(negedge clk);
        chk("midrst_bcd",   bus.bcd_out, 16'h0);
        chk("midrst_busy",  bus.busy, 1'b0);
        chk("midrst_anode", bus.anode, 4'hF);
        Reset = 1'b1;
        wait_bcd(16'h4321, "bcd_4321");

        // refresh rotation
        @(negedge clk);
        prev = bus.anode;
        for (int i = 0; i < 2 * (1 << RB); i++) begin
            @(negedge clk);
            chk("anode_onehot", $countones(~bus.anode), 1);
            if (bus.anode !== prev) chk("anode_step", bus.anode, {prev[2:0], prev[3]});
            prev = bus.anode;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
